// File: rtl/id_stage.sv
// RV32I-subset instruction decode: GPR read/forward, branch resolve, load-use detect, ID/EX register.
// Latency: 1 cycle IF/ID -> ID/EX; br_taken/br_addr/ld_hazard are combinational in the ID cycle.
// Backpressure: stall holds ID/EX; flush, ld_hazard or !if_en load a bubble (IF/ID retained upstream).
// Ports: clk/reset (async active-low); stall/flush control; if_* from IF/ID; gpr_rd_* to/from GPR file;
//        ex_* forwarding/hazard info from EX; br_* redirect to fetch; id_* registered ID/EX outputs.
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] if_pc,
  input  logic [31:0] if_insn,
  input  logic        if_en,
  output logic [4:0]  gpr_rd_addr_0,
  output logic [4:0]  gpr_rd_addr_1,
  input  logic [31:0] gpr_rd_data_0,
  input  logic [31:0] gpr_rd_data_1,
  input  logic        ex_en,
  input  logic        ex_gpr_we,
  input  logic        ex_mem_rd,
  input  logic [4:0]  ex_dst_addr,
  input  logic [31:0] ex_fwd_data,
  output logic        br_taken,
  output logic [29:0] br_addr,
  output logic        ld_hazard,
  output logic [29:0] id_pc,
  output logic        id_en,
  output logic [3:0]  id_alu_op,
  output logic [31:0] id_alu_in_0,
  output logic [31:0] id_alu_in_1,
  output logic [1:0]  id_mem_op,
  output logic [31:0] id_mem_wr_data,
  output logic [4:0]  id_dst_addr,
  output logic        id_gpr_we,
  output logic        id_illegal
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_PASS_B = 4'd10;
  localparam logic [1:0] MEM_NONE = 2'd0, MEM_LW = 2'd1, MEM_SW = 2'd2;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_u;

  assign opcode = if_insn[6:0];
  assign rd     = if_insn[11:7];
  assign funct3 = if_insn[14:12];
  assign rs1    = if_insn[19:15];
  assign rs2    = if_insn[24:20];
  assign funct7 = if_insn[31:25];
  assign imm_i  = {{20{if_insn[31]}}, if_insn[31:20]};
  assign imm_s  = {{20{if_insn[31]}}, if_insn[31:25], if_insn[11:7]};
  assign imm_u  = {if_insn[31:12], 12'd0};

  assign gpr_rd_addr_0 = rs1;
  assign gpr_rd_addr_1 = rs2;

  // Loads cannot forward: their data only exists after MEM, hence ld_hazard.
  logic        fwd_ok;
  logic [31:0] rs1_val, rs2_val;
  assign fwd_ok  = ex_en & ex_gpr_we & ~ex_mem_rd;
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 :
                   (fwd_ok && ex_dst_addr == rs1) ? ex_fwd_data : gpr_rd_data_0;
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 :
                   (fwd_ok && ex_dst_addr == rs2) ? ex_fwd_data : gpr_rd_data_1;

  logic        legal, use_rs1, use_rs2, is_br, is_jal, is_jalr, dec_we;
  logic [3:0]  dec_op;
  logic [31:0] dec_a, dec_b;
  logic [1:0]  dec_mem;
  logic [29:0] pc_inc;
  assign pc_inc = if_pc + 30'd1;

  always_comb begin
    legal   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    is_br   = 1'b0;
    is_jal  = 1'b0;
    is_jalr = 1'b0;
    dec_we  = 1'b0;
    dec_op  = ALU_ADD;
    dec_a   = rs1_val;
    dec_b   = rs2_val;
    dec_mem = MEM_NONE;
    case (opcode)
      OPC_LUI:    begin legal = 1'b1; dec_a = 32'd0; dec_b = imm_u; dec_op = ALU_PASS_B; dec_we = 1'b1; end
      OPC_AUIPC:  begin legal = 1'b1; dec_a = {if_pc, 2'b00}; dec_b = imm_u; dec_we = 1'b1; end
      OPC_JAL:    begin legal = 1'b1; is_jal = 1'b1; dec_a = {pc_inc, 2'b00}; dec_b = 32'd0; dec_we = 1'b1; end
      OPC_JALR: begin
        legal   = (funct3 == 3'd0);
        is_jalr = legal;
        use_rs1 = 1'b1;
        dec_a   = {pc_inc, 2'b00};
        dec_b   = 32'd0;
        dec_we  = 1'b1;
      end
      OPC_BRANCH: begin
        legal   = (funct3 != 3'd2) && (funct3 != 3'd3);
        is_br   = legal;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_op  = ALU_SUB;
      end
      OPC_LOAD:   begin legal = (funct3 == 3'd2); use_rs1 = 1'b1; dec_b = imm_i; dec_mem = MEM_LW; dec_we = 1'b1; end
      OPC_STORE:  begin legal = (funct3 == 3'd2); use_rs1 = 1'b1; use_rs2 = 1'b1; dec_b = imm_s; dec_mem = MEM_SW; end
      OPC_OPIMM: begin
        legal   = 1'b1;
        use_rs1 = 1'b1;
        dec_b   = imm_i;
        dec_we  = 1'b1;
        case (funct3)
          3'd0: dec_op = ALU_ADD;
          3'd1: begin dec_op = ALU_SLL; legal = (funct7 == 7'h00); dec_b = {27'd0, rs2}; end
          3'd2: dec_op = ALU_SLT;
          3'd3: dec_op = ALU_SLTU;
          3'd4: dec_op = ALU_XOR;
          3'd5: begin
            dec_op = funct7[5] ? ALU_SRA : ALU_SRL;
            legal  = (funct7 == 7'h00) || (funct7 == 7'h20);
            dec_b  = {27'd0, rs2};
          end
          3'd6: dec_op = ALU_OR;
          default: dec_op = ALU_AND;
        endcase
      end
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_we  = 1'b1;
        legal   = (funct7 == 7'h00) ||
                  ((funct7 == 7'h20) && (funct3 == 3'd0 || funct3 == 3'd5));
        case (funct3)
          3'd0: dec_op = funct7[5] ? ALU_SUB : ALU_ADD;
          3'd1: dec_op = ALU_SLL;
          3'd2: dec_op = ALU_SLT;
          3'd3: dec_op = ALU_SLTU;
          3'd4: dec_op = ALU_XOR;
          3'd5: dec_op = funct7[5] ? ALU_SRA : ALU_SRL;
          3'd6: dec_op = ALU_OR;
          default: dec_op = ALU_AND;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  logic br_cond;
  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      3'd0: br_cond = (rs1_val == rs2_val);
      3'd1: br_cond = (rs1_val != rs2_val);
      3'd4: br_cond = ($signed(rs1_val) <  $signed(rs2_val));
      3'd5: br_cond = ($signed(rs1_val) >= $signed(rs2_val));
      3'd6: br_cond = (rs1_val <  rs2_val);
      3'd7: br_cond = (rs1_val >= rs2_val);
      default: br_cond = 1'b0;
    endcase
  end

  // Word-granular offsets (imm[31:2]) added to the 30-bit PC wrap naturally;
  // imm[1] alone decides whether the byte target is halfword-misaligned.
  logic [29:0] jal_off, br_off, tgt;
  logic [30:0] jalr_sum;  // (rs1 + imm)[31:1]
  logic        tgt_b1, xfer, misalign;
  assign jal_off  = {{11{if_insn[31]}}, if_insn[31], if_insn[19:12], if_insn[20], if_insn[30:22]};
  assign br_off   = {{19{if_insn[31]}}, if_insn[31], if_insn[7], if_insn[30:25], if_insn[11:9]};
  assign jalr_sum = rs1_val[31:1] + imm_i[31:1] + {30'd0, rs1_val[0] & imm_i[0]};

  always_comb begin
    if (is_jalr) begin
      tgt    = jalr_sum[30:1];
      tgt_b1 = jalr_sum[0];
    end else if (is_jal) begin
      tgt    = if_pc + jal_off;
      tgt_b1 = if_insn[21];
    end else begin
      tgt    = if_pc + br_off;
      tgt_b1 = if_insn[8];
    end
  end

  assign xfer     = is_jal | is_jalr | (is_br & br_cond);
  assign misalign = xfer & tgt_b1;

  assign ld_hazard = if_en & ex_en & ex_mem_rd & (ex_dst_addr != 5'd0) &
                     ((use_rs1 && ex_dst_addr == rs1) || (use_rs2 && ex_dst_addr == rs2));
  assign br_taken  = if_en & ~ld_hazard & ~flush & xfer & ~misalign;
  assign br_addr   = br_taken ? tgt : 30'd0;

  logic ill;
  assign ill = ~legal | misalign;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_pc          <= 30'd0;
      id_en          <= 1'b0;
      id_alu_op      <= ALU_ADD;
      id_alu_in_0    <= 32'd0;
      id_alu_in_1    <= 32'd0;
      id_mem_op      <= MEM_NONE;
      id_mem_wr_data <= 32'd0;
      id_dst_addr    <= 5'd0;
      id_gpr_we      <= 1'b0;
      id_illegal     <= 1'b0;
    end else if (stall) begin
      // hold everything, flush included
    end else if (flush || ld_hazard || !if_en) begin
      id_pc      <= if_pc;
      id_en      <= 1'b0;
      id_gpr_we  <= 1'b0;
      id_mem_op  <= MEM_NONE;
      id_illegal <= 1'b0;
    end else begin
      id_pc          <= if_pc;
      id_en          <= 1'b1;
      id_alu_op      <= dec_op;
      id_alu_in_0    <= dec_a;
      id_alu_in_1    <= dec_b;
      id_mem_op      <= ill ? MEM_NONE : dec_mem;
      id_mem_wr_data <= rs2_val;
      id_dst_addr    <= rd;
      id_gpr_we      <= dec_we & ~ill & (rd != 5'd0);
      id_illegal     <= ill;
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage: stimulus pushes expected ID/EX contents into a queue,
// a monitor pops one entry after each active edge and compares; combinational outputs
// (br_taken/br_addr/ld_hazard) are compared by the stimulus in the ID cycle.
module tb_id_stage;
  logic        clk, reset, stall, flush, if_en;
  logic [29:0] if_pc;
  logic [31:0] if_insn;
  logic [4:0]  gpr_rd_addr_0, gpr_rd_addr_1;
  logic [31:0] gpr_rd_data_0, gpr_rd_data_1;
  logic        ex_en, ex_gpr_we, ex_mem_rd;
  logic [4:0]  ex_dst_addr;
  logic [31:0] ex_fwd_data;
  logic        br_taken, ld_hazard;
  logic [29:0] br_addr, id_pc;
  logic        id_en, id_gpr_we, id_illegal;
  logic [3:0]  id_alu_op;
  logic [31:0] id_alu_in_0, id_alu_in_1, id_mem_wr_data;
  logic [1:0]  id_mem_op;
  logic [4:0]  id_dst_addr;

  id_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en),
    .gpr_rd_addr_0(gpr_rd_addr_0), .gpr_rd_addr_1(gpr_rd_addr_1),
    .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
    .ex_en(ex_en), .ex_gpr_we(ex_gpr_we), .ex_mem_rd(ex_mem_rd),
    .ex_dst_addr(ex_dst_addr), .ex_fwd_data(ex_fwd_data),
    .br_taken(br_taken), .br_addr(br_addr), .ld_hazard(ld_hazard),
    .id_pc(id_pc), .id_en(id_en), .id_alu_op(id_alu_op),
    .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1), .id_mem_op(id_mem_op),
    .id_mem_wr_data(id_mem_wr_data), .id_dst_addr(id_dst_addr),
    .id_gpr_we(id_gpr_we), .id_illegal(id_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] M_PC = 6'd1, M_OP = 6'd2, M_A = 6'd4, M_B = 6'd8, M_DST = 6'd16, M_WD = 6'd32;
  localparam logic [5:0] M_ALU = 6'd31;

  typedef struct {
    int          tag;
    logic [5:0]  m;
    logic        en;
    logic [29:0] pc;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [1:0]  mem;
    logic [31:0] wd;
    logic [4:0]  dst;
    logic        we, ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endfunction

  function automatic exp_t mk(int tag, logic [5:0] m, logic en, logic [29:0] pc, logic [3:0] op,
                              logic [31:0] a, logic [31:0] b, logic [1:0] mem, logic [31:0] wd,
                              logic [4:0] dst, logic we, logic ill);
    exp_t e;
    e.tag = tag; e.m = m; e.en = en; e.pc = pc; e.op = op; e.a = a; e.b = b;
    e.mem = mem; e.wd = wd; e.dst = dst; e.we = we; e.ill = ill;
    return e;
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] r1, logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
    return {imm, r1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] r2, logic [4:0] r1, logic [2:0] f3, logic [4:0] rd);
    return {f7, r2, r1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] r2, logic [4:0] r1);
    return {imm[11:5], r2, r1, 3'd2, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] r2, logic [4:0] r1, logic [2:0] f3);
    return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  // Monitor: one expected entry per active edge the stimulus covered.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("v%0d.id_en", e.tag), {31'd0, id_en}, {31'd0, e.en});
        chk($sformatf("v%0d.id_gpr_we", e.tag), {31'd0, id_gpr_we}, {31'd0, e.we});
        chk($sformatf("v%0d.id_mem_op", e.tag), {30'd0, id_mem_op}, {30'd0, e.mem});
        chk($sformatf("v%0d.id_illegal", e.tag), {31'd0, id_illegal}, {31'd0, e.ill});
        if (e.m[0]) chk($sformatf("v%0d.id_pc", e.tag), {2'd0, id_pc}, {2'd0, e.pc});
        if (e.m[1]) chk($sformatf("v%0d.id_alu_op", e.tag), {28'd0, id_alu_op}, {28'd0, e.op});
        if (e.m[2]) chk($sformatf("v%0d.id_alu_in_0", e.tag), id_alu_in_0, e.a);
        if (e.m[3]) chk($sformatf("v%0d.id_alu_in_1", e.tag), id_alu_in_1, e.b);
        if (e.m[4]) chk($sformatf("v%0d.id_dst_addr", e.tag), {27'd0, id_dst_addr}, {27'd0, e.dst});
        if (e.m[5]) chk($sformatf("v%0d.id_mem_wr_data", e.tag), id_mem_wr_data, e.wd);
      end
    end
  end

  task automatic set_id(logic [29:0] pc, logic [31:0] insn, logic [31:0] d0, logic [31:0] d1);
    if_en = 1'b1; if_pc = pc; if_insn = insn; gpr_rd_data_0 = d0; gpr_rd_data_1 = d1;
  endtask
  task automatic set_ex(logic en, logic we, logic mr, logic [4:0] dst, logic [31:0] fwd);
    ex_en = en; ex_gpr_we = we; ex_mem_rd = mr; ex_dst_addr = dst; ex_fwd_data = fwd;
  endtask
  task automatic comb_chk(int tag, logic bt, logic [29:0] ba, logic lh);
    chk($sformatf("v%0d.br_taken", tag), {31'd0, br_taken}, {31'd0, bt});
    chk($sformatf("v%0d.br_addr", tag), {2'd0, br_addr}, {2'd0, ba});
    chk($sformatf("v%0d.ld_hazard", tag), {31'd0, ld_hazard}, {31'd0, lh});
  endtask
  task automatic chk_cleared(string pfx);
    chk({pfx, ".id_pc"}, {2'd0, id_pc}, 32'd0);
    chk({pfx, ".id_en"}, {31'd0, id_en}, 32'd0);
    chk({pfx, ".id_alu_op"}, {28'd0, id_alu_op}, 32'd0);
    chk({pfx, ".id_alu_in_0"}, id_alu_in_0, 32'd0);
    chk({pfx, ".id_alu_in_1"}, id_alu_in_1, 32'd0);
    chk({pfx, ".id_mem_op"}, {30'd0, id_mem_op}, 32'd0);
    chk({pfx, ".id_gpr_we"}, {31'd0, id_gpr_we}, 32'd0);
    chk({pfx, ".id_illegal"}, {31'd0, id_illegal}, 32'd0);
  endtask

  initial begin
    exp_t held;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(30'd0, 32'd0, 32'd0, 32'd0); if_en = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    #1 reset = 1'b0;
    #1 chk_cleared("reset");
    @(negedge clk); reset = 1'b1;

    // Forwarding from EX: ADDI x4,x3,1 with x3 in flight as 0x1234
    @(negedge clk); set_id(30'h40, enc_i(12'd1, 5'd3, 3'd0, 5'd4, 7'h13), 32'hDEAD, 32'h55);
    set_ex(1'b1, 1'b1, 1'b0, 5'd3, 32'h1234);
    #1 comb_chk(1, 1'b0, 30'd0, 1'b0);
    chk("v1.gpr_rd_addr_0", {27'd0, gpr_rd_addr_0}, 32'd3);
    chk("v1.gpr_rd_addr_1", {27'd0, gpr_rd_addr_1}, 32'd1);
    exp_q.push_back(mk(1, M_ALU, 1, 30'h40, 4'd0, 32'h1234, 32'd1, 2'd0, 0, 5'd4, 1, 0));

    // Load-use: EX has LW x5, ID has ADD x6,x5,x1 -> bubble, then decode with EX idle
    @(negedge clk); set_id(30'h44, enc_r(7'h00, 5'd1, 5'd5, 3'd0, 5'd6), 32'h70, 32'h8);
    set_ex(1'b1, 1'b1, 1'b1, 5'd5, 32'h999);
    #1 comb_chk(2, 1'b0, 30'd0, 1'b1);
    exp_q.push_back(mk(2, 6'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
    @(negedge clk); set_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    #1 comb_chk(3, 1'b0, 30'd0, 1'b0);
    exp_q.push_back(mk(3, M_ALU, 1, 30'h44, 4'd0, 32'h70, 32'h8, 2'd0, 0, 5'd6, 1, 0));

    // Load in EX targets the rs2 field of an ADDI, which ADDI does not read
    @(negedge clk); set_id(30'h48, enc_i(12'd1, 5'd3, 3'd0, 5'd4, 7'h13), 32'h300, 32'h0);
    set_ex(1'b1, 1'b1, 1'b1, 5'd1, 32'h999);
    #1 comb_chk(4, 1'b0, 30'd0, 1'b0);
    exp_q.push_back(mk(4, M_ALU, 1, 30'h48, 4'd0, 32'h300, 32'd1, 2'd0, 0, 5'd4, 1, 0));

    // x0 reads zero even if EX claims to write x0
    @(negedge clk); set_id(30'h4C, enc_r(7'h00, 5'd2, 5'd0, 3'd0, 5'd7), 32'hBAD, 32'h22);
    set_ex(1'b1, 1'b1, 1'b0, 5'd0, 32'h777);
    #1 exp_q.push_back(mk(5, M_ALU, 1, 30'h4C, 4'd0, 32'd0, 32'h22, 2'd0, 0, 5'd7, 1, 0));

    // Branches at pc 0x100, offset +16 -> word 0x104
    @(negedge clk); set_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    set_id(30'h100, enc_b(13'd16, 5'd2, 5'd1, 3'd0), 32'd7, 32'd7);
    #1 comb_chk(6, 1'b1, 30'h104, 1'b0);
    exp_q.push_back(mk(6, M_PC, 1, 30'h100, 0, 0, 0, 2'd0, 0, 0, 0, 0));
    @(negedge clk); gpr_rd_data_1 = 32'd8;
    #1 comb_chk(7, 1'b0, 30'd0, 1'b0);
    exp_q.push_back(mk(7, M_PC, 1, 30'h100, 0, 0, 0, 2'd0, 0, 0, 0, 0));
    @(negedge clk); set_id(30'h100, enc_b(13'd16, 5'd2, 5'd1, 3'd4), 32'hFFFF_FFFF, 32'd1);
    #1 comb_chk(8, 1'b1, 30'h104, 1'b0);
    exp_q.push_back(mk(8, M_PC, 1, 30'h100, 0, 0, 0, 2'd0, 0, 0, 0, 0));
    @(negedge clk); set_id(30'h100, enc_b(13'd16, 5'd2, 5'd1, 3'd6), 32'hFFFF_FFFF, 32'd1);
    #1 comb_chk(9, 1'b0, 30'd0, 1'b0);
    exp_q.push_back(mk(9, M_PC, 1, 30'h100, 0, 0, 0, 2'd0, 0, 0, 0, 0));

    // JAL x1,+8 from the last word: target and link both wrap
    @(negedge clk); set_id(30'h3FFF_FFFF, enc_j(21'd8, 5'd1), 32'd0, 32'd0);
    #1 comb_chk(10, 1'b1, 30'h1, 1'b0);
    exp_q.push_back(mk(10, M_ALU, 1, 30'h3FFF_FFFF, 4'd0, 32'd0, 32'd0, 2'd0, 0, 5'd1, 1, 0));

    // JALR x1,4(x2) with x2=0x200 -> byte 0x204; then imm 2 from 0x100 -> misaligned
    @(negedge clk); set_id(30'h20, enc_i(12'd4, 5'd2, 3'd0, 5'd1, 7'h67), 32'h200, 32'd0);
    #1 comb_chk(11, 1'b1, 30'h81, 1'b0);
    exp_q.push_back(mk(11, M_ALU, 1, 30'h20, 4'd0, 32'h84, 32'd0, 2'd0, 0, 5'd1, 1, 0));
    @(negedge clk); set_id(30'h20, enc_i(12'd2, 5'd2, 3'd0, 5'd1, 7'h67), 32'h100, 32'd0);
    #1 comb_chk(12, 1'b0, 30'd0, 1'b0);
    exp_q.push_back(mk(12, M_PC, 1, 30'h20, 0, 0, 0, 2'd0, 0, 0, 0, 1));

    // All-ones encoding is illegal
    @(negedge clk); set_id(30'h24, 32'hFFFF_FFFF, 32'd0, 32'd0);
    #1 comb_chk(13, 1'b0, 30'd0, 1'b0);
    exp_q.push_back(mk(13, M_PC, 1, 30'h24, 0, 0, 0, 2'd0, 0, 0, 0, 1));

    // SW x2,8(x1); LW x9,4(x1); LUI; AUIPC; SUB; SRAI; SLTU; ADDI to x0; LB (illegal)
    @(negedge clk); set_id(30'h28, enc_s(12'd8, 5'd2, 5'd1), 32'h1000, 32'hCAFE_F00D);
    #1 exp_q.push_back(mk(14, M_PC | M_OP | M_A | M_B | M_WD, 1, 30'h28, 4'd0, 32'h1000, 32'd8, 2'd2, 32'hCAFE_F00D, 0, 0, 0));
    @(negedge clk); set_id(30'h2C, enc_i(12'd4, 5'd1, 3'd2, 5'd9, 7'h03), 32'h2000, 32'd0);
    #1 exp_q.push_back(mk(15, M_ALU, 1, 30'h2C, 4'd0, 32'h2000, 32'd4, 2'd1, 0, 5'd9, 1, 0));
    @(negedge clk); set_id(30'h30, {20'h12345, 5'd10, 7'h37}, 32'd0, 32'd0);
    #1 exp_q.push_back(mk(16, M_PC | M_OP | M_B | M_DST, 1, 30'h30, 4'd10, 0, 32'h1234_5000, 2'd0, 0, 5'd10, 1, 0));
    @(negedge clk); set_id(30'h10, {20'h00001, 5'd11, 7'h17}, 32'd0, 32'd0);
    #1 exp_q.push_back(mk(17, M_ALU, 1, 30'h10, 4'd0, 32'h40, 32'h1000, 2'd0, 0, 5'd11, 1, 0));
    @(negedge clk); set_id(30'h34, enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd12), 32'd10, 32'd3);
    #1 exp_q.push_back(mk(18, M_ALU, 1, 30'h34, 4'd1, 32'd10, 32'd3, 2'd0, 0, 5'd12, 1, 0));
    @(negedge clk); set_id(30'h38, enc_i(12'h403, 5'd1, 3'd5, 5'd13, 7'h13), 32'h8000_0000, 32'd0);
    #1 exp_q.push_back(mk(19, M_PC | M_OP | M_A | M_DST, 1, 30'h38, 4'd7, 32'h8000_0000, 0, 2'd0, 0, 5'd13, 1, 0));
    @(negedge clk); set_id(30'h3C, enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd14), 32'd5, 32'd6);
    #1 exp_q.push_back(mk(20, M_ALU, 1, 30'h3C, 4'd9, 32'd5, 32'd6, 2'd0, 0, 5'd14, 1, 0));
    @(negedge clk); set_id(30'h50, enc_i(12'd5, 5'd1, 3'd0, 5'd0, 7'h13), 32'd1, 32'd0);
    #1 exp_q.push_back(mk(21, M_PC | M_OP | M_DST, 1, 30'h50, 4'd0, 0, 0, 2'd0, 0, 5'd0, 0, 0));
    @(negedge clk); set_id(30'h54, enc_i(12'd0, 5'd1, 3'd0, 5'd5, 7'h03), 32'd1, 32'd0);
    #1 exp_q.push_back(mk(22, M_PC, 1, 30'h54, 0, 0, 0, 2'd0, 0, 0, 0, 1));

    // if_en low -> bubble
    @(negedge clk); set_id(30'h58, enc_i(12'd1, 5'd3, 3'd0, 5'd4, 7'h13), 32'd1, 32'd0); if_en = 1'b0;
    #1 exp_q.push_back(mk(23, 6'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0));

    // Control priority: load, stall+flush holds, flush bubbles, stall holds the bubble
    @(negedge clk); set_id(30'h60, enc_i(12'd1, 5'd3, 3'd0, 5'd4, 7'h13), 32'd5, 32'd0);
    #1 held = mk(24, M_ALU, 1, 30'h60, 4'd0, 32'd5, 32'd1, 2'd0, 0, 5'd4, 1, 0);
    exp_q.push_back(held);
    @(negedge clk); set_id(30'h64, enc_j(21'd8, 5'd1), 32'd0, 32'd0); stall = 1'b1; flush = 1'b1;
    #1 comb_chk(25, 1'b0, 30'd0, 1'b0);
    held.tag = 25; exp_q.push_back(held);
    @(negedge clk); if_pc = 30'h68; stall = 1'b0;
    #1 comb_chk(26, 1'b0, 30'd0, 1'b0);
    held = mk(26, M_PC, 0, 30'h68, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    exp_q.push_back(held);
    @(negedge clk); set_id(30'h6C, enc_i(12'd1, 5'd3, 3'd0, 5'd4, 7'h13), 32'd7, 32'd0); stall = 1'b1; flush = 1'b0;
    #1 held.tag = 27; exp_q.push_back(held);
    @(negedge clk); set_id(30'h70, enc_i(12'd1, 5'd3, 3'd0, 5'd4, 7'h13), 32'd9, 32'd0); stall = 1'b0;
    #1 exp_q.push_back(mk(28, M_ALU, 1, 30'h70, 4'd0, 32'd9, 32'd1, 2'd0, 0, 5'd4, 1, 0));

    // Asynchronous reset mid-cycle, then first edge after release loads normally
    @(posedge clk); #3 reset = 1'b0;
    #1 chk_cleared("midreset");
    @(negedge clk); reset = 1'b1;
    set_id(30'h74, enc_i(12'd1, 5'd3, 3'd0, 5'd4, 7'h13), 32'h11, 32'd0);
    #1 exp_q.push_back(mk(29, M_ALU, 1, 30'h74, 4'd0, 32'h11, 32'd1, 2'd0, 0, 5'd4, 1, 0));

    @(negedge clk); if_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
